// File: rtl/cnn_datapath_gen_if.sv
// Purpose: control/status bundle between the control unit (master) and cnn_datapath_gen (slave).
// Latency: none, wires only.
// Backpressure: none; the control unit strobes every cycle and the datapath never stalls.
//
// master: drives bus select, load/increment strobes, loop/flag controls, MAC issue, memory read data.
// slave : returns bus/memory taps, register taps, loop terminal flags, MAC busy and status flags.
interface cnn_datapath_gen_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int NREG   = 8,
   parameter int LOOP_W = 4,
   parameter int SEL_W  = $clog2(NREG + 6),
   parameter int IDX_W  = $clog2(NREG)
);
   // control unit -> datapath
   logic [SEL_W-1:0]  bus_sel;
   logic [NREG-1:0]   reg_load;
   logic              ac_load;
   logic              pc_load;
   logic              pc_inc;
   logic              ar_load;
   logic              ar_inc;
   logic              i_clr;
   logic              i_inc;
   logic              j_clr;
   logic [LOOP_W-1:0] i_limit;
   logic [LOOP_W-1:0] j_limit;
   logic              flag_en;
   logic              flag_clr;
   logic [DATA_W-1:0] compare_val;
   logic              mac_valid;
   logic [IDX_W-1:0]  mac_a_idx;
   logic [IDX_W-1:0]  mac_b_idx;
   logic [DATA_W-1:0] from_memory;

   // datapath -> control unit / memory
   logic [DATA_W-1:0] to_memory;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] bus_value;
   logic [DATA_W-1:0] ac_value;
   logic [ADDR_W-1:0] pc_value;
   logic [ADDR_W-1:0] ar_value;
   logic [LOOP_W-1:0] i_value;
   logic [LOOP_W-1:0] j_value;
   logic              i_last;
   logic              j_last;
   logic              mac_busy;
   logic              zero;
   logic              neg;
   logic              equal;
   logic              ovf;

   modport master (
      output bus_sel, reg_load, ac_load, pc_load, pc_inc, ar_load, ar_inc,
             i_clr, i_inc, j_clr, i_limit, j_limit, flag_en, flag_clr, compare_val,
             mac_valid, mac_a_idx, mac_b_idx, from_memory,
      input  to_memory, address, bus_value, ac_value, pc_value, ar_value,
             i_value, j_value, i_last, j_last, mac_busy, zero, neg, equal, ovf
   );

   modport slave (
      input  bus_sel, reg_load, ac_load, pc_load, pc_inc, ar_load, ar_inc,
             i_clr, i_inc, j_clr, i_limit, j_limit, flag_en, flag_clr, compare_val,
             mac_valid, mac_a_idx, mac_b_idx, from_memory,
      output to_memory, address, bus_value, ac_value, pc_value, ar_value,
             i_value, j_value, i_last, j_last, mac_busy, zero, neg, equal, ovf
   );
endinterface

// File: rtl/cnn_datapath_gen.sv
// Purpose: CNN datapath - register file, shared bus, PC/AR, flags, I/J loop counters, pipelined fixed-point MAC into AC.
// Latency: loads/counters 1 cycle; MAC issued at edge t writes AC at edge t+MAC_STAGES, one issue per cycle.
// Backpressure: none; every strobe is acted on in the cycle it is presented, the control unit owns sequencing.
//
// Ports: clk, rst (async active-high); dp = cnn_datapath_gen_if.slave carrying all control strobes,
//        memory read data, bus/address outputs, register taps, loop flags, mac_busy and status flags.
// Build option: define MAC_SAT_EN to saturate product narrowing and accumulation instead of wrapping.
module cnn_datapath_gen #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 12,
   parameter int NREG       = 8,
   parameter int LOOP_W     = 4,
   parameter int FRAC_W     = 8,
   parameter int MAC_STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   cnn_datapath_gen_if.slave dp
);
   localparam int SEL_W = $clog2(NREG + 6);
   localparam int IDX_W = $clog2(NREG);
   localparam int PW    = 2 * DATA_W;

   localparam logic [SEL_W-1:0] SEL_AC  = SEL_W'(NREG);
   localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NREG + 1);
   localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(NREG + 2);
   localparam logic [SEL_W-1:0] SEL_I   = SEL_W'(NREG + 3);
   localparam logic [SEL_W-1:0] SEL_J   = SEL_W'(NREG + 4);

   localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [DATA_W-1:0] r_q [NREG];
   logic [DATA_W-1:0] r_d [NREG];
   logic [DATA_W-1:0] ac_q, ac_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ar_q, ar_d;
   logic [LOOP_W-1:0] i_q, i_d;
   logic [LOOP_W-1:0] j_q, j_d;
   logic              zero_q, zero_d;
   logic              neg_q, neg_d;
   logic              equal_q, equal_d;
   logic              ovf_q, ovf_d;

   logic signed [DATA_W-1:0] opa_q, opa_d;
   logic signed [DATA_W-1:0] opb_q, opb_d;
   logic [MAC_STAGES-1:0]    vld_q, vld_d;

   logic [DATA_W-1:0] bus;
   logic              i_last;
   logic              j_last;
   logic              i_carry;

   // ---------------------------------------------------------------
   // Shared bus
   // ---------------------------------------------------------------
   always_comb begin
      bus = '0;
      if (dp.bus_sel < SEL_AC) begin
         bus = r_q[dp.bus_sel[IDX_W-1:0]];
      end else begin
         case (dp.bus_sel)
            SEL_AC:  bus = ac_q;
            SEL_PC:  bus = DATA_W'(pc_q);
            SEL_MEM: bus = dp.from_memory;
            SEL_I:   bus = DATA_W'(i_q);
            SEL_J:   bus = DATA_W'(j_q);
            default: bus = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // MAC datapath
   // Stage 0 holds the captured operands; the narrowed product is formed
   // from it and delayed to the last stage, where it is added to the AC
   // value present at the retire edge so back-to-back ops chain correctly.
   // ---------------------------------------------------------------
   logic signed [PW-1:0] prod_full;
   logic signed [PW-1:0] prod_shr;
   logic [DATA_W:0]      prod_top;
   logic                 nar_ovf;
   logic [DATA_W-1:0]    prod_nar;
   logic [DATA_W-1:0]    ret_prod;
   logic                 ret_novf;
   logic                 retire;
   logic [DATA_W:0]      sum_full;
   logic                 sum_ovf;
   logic [DATA_W-1:0]    sum_nar;
   logic                 ovf_evt;

   always_comb begin
      prod_full = PW'(opa_q) * PW'(opb_q);
      prod_shr  = prod_full >>> FRAC_W;
      // The narrowed value fits only if every bit from the sign position up agrees.
      prod_top  = prod_shr[PW-1:DATA_W-1];
      nar_ovf   = !((&prod_top) || !(|prod_top));
`ifdef MAC_SAT_EN
      if (nar_ovf) begin
         prod_nar = prod_shr[PW-1] ? SMIN : SMAX;
      end else begin
         prod_nar = prod_shr[DATA_W-1:0];
      end
`else
      prod_nar = prod_shr[DATA_W-1:0];
`endif
   end

   generate
      if (MAC_STAGES == 1) begin : g_mac_comb
         assign ret_prod = prod_nar;
         assign ret_novf = nar_ovf;
      end else begin : g_mac_pipe
         logic [DATA_W-1:0] prod_q [1:MAC_STAGES-1];
         logic              novf_q [1:MAC_STAGES-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 1; k < MAC_STAGES; k++) begin
                  prod_q[k] <= '0;
                  novf_q[k] <= 1'b0;
               end
            end else begin
               prod_q[1] <= prod_nar;
               novf_q[1] <= nar_ovf;
               for (int k = 2; k < MAC_STAGES; k++) begin
                  prod_q[k] <= prod_q[k-1];
                  novf_q[k] <= novf_q[k-1];
               end
            end
         end

         assign ret_prod = prod_q[MAC_STAGES-1];
         assign ret_novf = novf_q[MAC_STAGES-1];
      end
   endgenerate

   assign retire = vld_q[MAC_STAGES-1];

   always_comb begin
      sum_full = {ac_q[DATA_W-1], ac_q} + {ret_prod[DATA_W-1], ret_prod};
      sum_ovf  = sum_full[DATA_W] ^ sum_full[DATA_W-1];
`ifdef MAC_SAT_EN
      if (sum_ovf) begin
         sum_nar = sum_full[DATA_W] ? SMIN : SMAX;
      end else begin
         sum_nar = sum_full[DATA_W-1:0];
      end
`else
      sum_nar = sum_full[DATA_W-1:0];
`endif
      ovf_evt = retire && (ret_novf || sum_ovf);
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   assign i_last  = (i_q == dp.i_limit);
   assign j_last  = (j_q == dp.j_limit);
   // i_clr suppresses the carry because it overrides the increment entirely.
   assign i_carry = !dp.i_clr && dp.i_inc && i_last;

   always_comb begin
      for (int k = 0; k < NREG; k++) begin
         r_d[k] = dp.reg_load[k] ? bus : r_q[k];
      end

      // An explicit AC load beats a retiring MAC; the retire still reports overflow.
      if (dp.ac_load) begin
         ac_d = bus;
      end else if (retire) begin
         ac_d = sum_nar;
      end else begin
         ac_d = ac_q;
      end

      if (dp.pc_load) begin
         pc_d = bus[ADDR_W-1:0];
      end else if (dp.pc_inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end else begin
         pc_d = pc_q;
      end

      if (dp.ar_load) begin
         ar_d = bus[ADDR_W-1:0];
      end else if (dp.ar_inc) begin
         ar_d = ar_q + ADDR_W'(1);
      end else begin
         ar_d = ar_q;
      end

      if (dp.i_clr) begin
         i_d = '0;
      end else if (dp.i_inc) begin
         i_d = i_last ? '0 : i_q + LOOP_W'(1);
      end else begin
         i_d = i_q;
      end

      if (dp.j_clr) begin
         j_d = '0;
      end else if (i_carry) begin
         j_d = j_last ? '0 : j_q + LOOP_W'(1);
      end else begin
         j_d = j_q;
      end

      if (dp.flag_en) begin
         zero_d  = (bus == '0);
         neg_d   = bus[DATA_W-1];
         equal_d = (bus == dp.compare_val);
      end else begin
         zero_d  = zero_q;
         neg_d   = neg_q;
         equal_d = equal_q;
      end

      // Sticky: a fresh overflow in the same cycle outranks the clear.
      if (ovf_evt) begin
         ovf_d = 1'b1;
      end else if (dp.flag_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      // Operands are taken from pre-edge register values, so a same-cycle
      // register write does not affect the op being issued.
      opa_d = dp.mac_valid ? r_q[dp.mac_a_idx] : opa_q;
      opb_d = dp.mac_valid ? r_q[dp.mac_b_idx] : opb_q;
      vld_d = (vld_q << 1) | MAC_STAGES'(dp.mac_valid);
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) begin
            r_q[k] <= '0;
         end
         ac_q    <= '0;
         pc_q    <= '0;
         ar_q    <= '0;
         i_q     <= '0;
         j_q     <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         equal_q <= 1'b0;
         ovf_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         vld_q   <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            r_q[k] <= r_d[k];
         end
         ac_q    <= ac_d;
         pc_q    <= pc_d;
         ar_q    <= ar_d;
         i_q     <= i_d;
         j_q     <= j_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         equal_q <= equal_d;
         ovf_q   <= ovf_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         vld_q   <= vld_d;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign dp.to_memory = bus;
   assign dp.bus_value = bus;
   assign dp.address   = ar_q;
   assign dp.ac_value  = ac_q;
   assign dp.pc_value  = pc_q;
   assign dp.ar_value  = ar_q;
   assign dp.i_value   = i_q;
   assign dp.j_value   = j_q;
   assign dp.i_last    = i_last;
   assign dp.j_last    = j_last;
   assign dp.mac_busy  = |vld_q;
   assign dp.zero      = zero_q;
   assign dp.neg       = neg_q;
   assign dp.equal     = equal_q;
   assign dp.ovf       = ovf_q;
endmodule

// File: tb/tb_cnn_datapath_gen.sv
// Purpose: self-checking bench for cnn_datapath_gen with directed scenarios and a randomized MAC stream.
// Latency: follows the DUT; inputs change #1 after a rising edge, outputs are sampled there too.
// Backpressure: none; every wait is a fixed number of clock steps plus a global watchdog.
module tb_cnn_datapath_gen;
   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 12;
   localparam int NREG       = 8;
   localparam int LOOP_W     = 4;
   localparam int FRAC_W     = 8;
   localparam int MAC_STAGES = 2;
   localparam int SEL_W      = $clog2(NREG + 6);
   localparam int IDX_W      = $clog2(NREG);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cnn_datapath_gen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .LOOP_W(LOOP_W)) dif ();

   cnn_datapath_gen #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .LOOP_W(LOOP_W),
      .FRAC_W(FRAC_W), .MAC_STAGES(MAC_STAGES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dp (dif)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int                ret;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } mac_op_t;

   // Reference MAC: plain integer arithmetic on the signed fixed-point values.
   function automatic logic [DATA_W-1:0] mac_ref(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 output bit ov);
      longint maxv = (64'sd1 <<< (DATA_W - 1)) - 1;
      longint minv = -(64'sd1 <<< (DATA_W - 1));
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint sc = $signed(acc);
      longint p, s;
      logic signed [DATA_W-1:0] t;
      ov = 1'b0;
      p = (sa * sb) >>> FRAC_W;
      if (p > maxv || p < minv) begin
         ov = 1'b1;
`ifdef MAC_SAT_EN
         p = (p > maxv) ? maxv : minv;
`else
         t = p[DATA_W-1:0];
         p = t;
`endif
      end
      s = sc + p;
      if (s > maxv || s < minv) begin
         ov = 1'b1;
`ifdef MAC_SAT_EN
         s = (s > maxv) ? maxv : minv;
`else
         t = s[DATA_W-1:0];
         s = t;
`endif
      end
      return s[DATA_W-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dif.bus_sel     = '0;
      dif.reg_load    = '0;
      dif.ac_load     = 1'b0;
      dif.pc_load     = 1'b0;
      dif.pc_inc      = 1'b0;
      dif.ar_load     = 1'b0;
      dif.ar_inc      = 1'b0;
      dif.i_clr       = 1'b0;
      dif.i_inc       = 1'b0;
      dif.j_clr       = 1'b0;
      dif.flag_en     = 1'b0;
      dif.flag_clr    = 1'b0;
      dif.mac_valid   = 1'b0;
      dif.mac_a_idx   = '0;
      dif.mac_b_idx   = '0;
   endtask

   task automatic drive_mem(input logic [DATA_W-1:0] v);
      dif.bus_sel     = SEL_W'(NREG + 2);
      dif.from_memory = v;
   endtask

   task automatic load_reg(input int idx, input logic [DATA_W-1:0] v);
      idle();
      drive_mem(v);
      dif.reg_load = NREG'(1) << idx;
      step();
      idle();
   endtask

   task automatic load_ac(input logic [DATA_W-1:0] v);
      idle();
      drive_mem(v);
      dif.ac_load = 1'b1;
      step();
      idle();
   endtask

   task automatic issue(input int a, input int b);
      dif.mac_valid = 1'b1;
      dif.mac_a_idx = IDX_W'(a);
      dif.mac_b_idx = IDX_W'(b);
      step();
      dif.mac_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      dif.i_limit = '0;
      dif.j_limit = '0;
      dif.compare_val = '0;
      dif.from_memory = '0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      step();
      checks++;
      if (dif.ac_value !== '0 || dif.pc_value !== '0 || dif.ar_value !== '0) begin
         errors++;
         $display("FAIL reset_regs: ac=%h pc=%h ar=%h required all 0", dif.ac_value, dif.pc_value, dif.ar_value);
      end
      checks++;
      if (dif.i_value !== '0 || dif.j_value !== '0 || dif.i_last !== 1'b1) begin
         errors++;
         $display("FAIL reset_loops: i=%0d j=%0d i_last=%b required 0 0 1", dif.i_value, dif.j_value, dif.i_last);
      end
      checks++;
      if ({dif.zero, dif.neg, dif.equal, dif.ovf, dif.mac_busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: z/n/e/o/busy=%b required 00000",
                  {dif.zero, dif.neg, dif.equal, dif.ovf, dif.mac_busy});
      end
      checks++;
      if (dif.bus_value !== '0) begin
         errors++;
         $display("FAIL reset_r0: bus=%h required 0000", dif.bus_value);
      end
   endtask

   task automatic test_pc_ar();
      idle();
      drive_mem(16'h0FFF);
      dif.pc_load = 1'b1;
      dif.ar_load = 1'b1;
      step();
      idle();
      dif.pc_inc = 1'b1;
      dif.ar_inc = 1'b1;
      step();
      idle();
      checks++;
      if (dif.pc_value !== 12'h000 || dif.address !== 12'h000) begin
         errors++;
         $display("FAIL pc_ar_wrap: pc=%h addr=%h required 000 000", dif.pc_value, dif.address);
      end
      drive_mem(16'hF123);
      dif.pc_load = 1'b1;
      dif.pc_inc  = 1'b1;
      step();
      idle();
      checks++;
      if (dif.pc_value !== 12'h123) begin
         errors++;
         $display("FAIL pc_load_prio: pc=%h required 123", dif.pc_value);
      end
      dif.bus_sel = SEL_W'(NREG + 1);
      #1;
      checks++;
      if (dif.bus_value !== 16'h0123) begin
         errors++;
         $display("FAIL bus_pc: bus=%h required 0123", dif.bus_value);
      end
      drive_mem(16'h0ABC);
      dif.ar_load = 1'b1;
      dif.ar_inc  = 1'b1;
      step();
      idle();
      dif.ar_inc = 1'b1;
      step();
      idle();
      checks++;
      if (dif.address !== 12'hABD || dif.ar_value !== 12'hABD) begin
         errors++;
         $display("FAIL ar_seq: addr=%h ar=%h required ABD", dif.address, dif.ar_value);
      end
   endtask

   task automatic test_bus_flags();
      idle();
      drive_mem(16'h8000);
      dif.compare_val = 16'h8000;
      dif.flag_en = 1'b1;
      #1;
      checks++;
      if (dif.bus_value !== 16'h8000 || dif.to_memory !== 16'h8000) begin
         errors++;
         $display("FAIL bus_mem: bus=%h to_mem=%h required 8000", dif.bus_value, dif.to_memory);
      end
      step();
      checks++;
      if ({dif.zero, dif.neg, dif.equal} !== 3'b011) begin
         errors++;
         $display("FAIL flags_neg: z/n/e=%b required 011", {dif.zero, dif.neg, dif.equal});
      end
      drive_mem(16'h0000);
      dif.compare_val = 16'h0005;
      step();
      checks++;
      if ({dif.zero, dif.neg, dif.equal} !== 3'b100) begin
         errors++;
         $display("FAIL flags_zero: z/n/e=%b required 100", {dif.zero, dif.neg, dif.equal});
      end
      dif.flag_en = 1'b0;
      drive_mem(16'h8005);
      step();
      checks++;
      if ({dif.zero, dif.neg, dif.equal} !== 3'b100) begin
         errors++;
         $display("FAIL flags_hold: z/n/e=%b required 100", {dif.zero, dif.neg, dif.equal});
      end
      for (int s = NREG + 5; s < (1 << SEL_W); s++) begin
         dif.bus_sel = SEL_W'(s);
         #1;
         checks++;
         if (dif.bus_value !== '0) begin
            errors++;
            $display("FAIL bus_unused: sel=%0d bus=%h required 0000", s, dif.bus_value);
         end
      end
      // One bus value fanning out to R5, AC and PC in the same cycle.
      drive_mem(16'h5A5A);
      dif.reg_load = NREG'(1) << 5;
      dif.ac_load  = 1'b1;
      dif.pc_load  = 1'b1;
      step();
      idle();
      dif.bus_sel = SEL_W'(5);
      #1;
      checks++;
      if (dif.bus_value !== 16'h5A5A || dif.ac_value !== 16'h5A5A || dif.pc_value !== 12'hA5A) begin
         errors++;
         $display("FAIL multi_load: r5=%h ac=%h pc=%h required 5A5A 5A5A A5A",
                  dif.bus_value, dif.ac_value, dif.pc_value);
      end
   endtask

   task automatic test_loops();
      int il, jl, n, ei, ej;
      // Directed limits first, then random limits with sparse increments.
      for (int pass = 0; pass < 6; pass++) begin
         if (pass == 0) begin il = 2; jl = 1; end
         else if (pass == 1) begin il = 0; jl = 3; end
         else begin il = $urandom_range(0, 3); jl = $urandom_range(0, 3); end
         idle();
         dif.i_limit = LOOP_W'(il);
         dif.j_limit = LOOP_W'(jl);
         dif.i_clr = 1'b1;
         dif.j_clr = 1'b1;
         step();
         idle();
         n = 0;
         for (int c = 0; c < 10; c++) begin
            dif.i_inc = (pass < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (dif.i_inc) n++;
            step();
            idle();
            ei = n % (il + 1);
            ej = (n / (il + 1)) % (jl + 1);
            checks++;
            if (dif.i_value !== LOOP_W'(ei) || dif.j_value !== LOOP_W'(ej) ||
                dif.i_last !== (ei == il) || dif.j_last !== (ej == jl)) begin
               errors++;
               $display("FAIL loop_seq: lim=%0d/%0d n=%0d got I=%0d J=%0d il=%b jl=%b required I=%0d J=%0d",
                        il, jl, n, dif.i_value, dif.j_value, dif.i_last, dif.j_last, ei, ej);
            end
         end
      end
      // Clear priorities: i_clr blocks the carry; j_clr beats the carry.
      idle();
      dif.i_limit = 4'd1;
      dif.j_limit = 4'd3;
      dif.i_clr = 1'b1;
      dif.j_clr = 1'b1;
      step();
      idle();
      dif.i_inc = 1'b1;
      repeat (3) step();
      dif.i_clr = 1'b1;
      step();
      idle();
      checks++;
      if (dif.i_value !== 4'd0 || dif.j_value !== 4'd1) begin
         errors++;
         $display("FAIL i_clr_prio: I=%0d J=%0d required 0 1", dif.i_value, dif.j_value);
      end
      dif.i_inc = 1'b1;
      step();
      dif.bus_sel = SEL_W'(NREG + 3);
      #1;
      checks++;
      if (dif.bus_value !== 16'd1) begin
         errors++;
         $display("FAIL bus_i: bus=%h required 0001", dif.bus_value);
      end
      dif.j_clr = 1'b1;
      step();
      idle();
      checks++;
      if (dif.i_value !== 4'd0 || dif.j_value !== 4'd0) begin
         errors++;
         $display("FAIL j_clr_prio: I=%0d J=%0d required 0 0", dif.i_value, dif.j_value);
      end
   endtask

   task automatic test_mac_single();
      load_reg(0, 16'h0200);
      load_reg(1, 16'h0180);
      load_ac(16'h0000);
      issue(0, 1);
      checks++;
      if (dif.mac_busy !== 1'b1 || dif.ac_value !== 16'h0000) begin
         errors++;
         $display("FAIL mac_issue: busy=%b ac=%h required 1 0000", dif.mac_busy, dif.ac_value);
      end
      repeat (MAC_STAGES - 1) begin
         step();
         checks++;
         if (dif.ac_value !== 16'h0000) begin
            errors++;
            $display("FAIL mac_early: ac=%h required 0000 before retire", dif.ac_value);
         end
      end
      step();
      checks++;
      if (dif.ac_value !== 16'h0300 || dif.mac_busy !== 1'b0) begin
         errors++;
         $display("FAIL mac_single: ac=%h busy=%b required 0300 0", dif.ac_value, dif.mac_busy);
      end
   endtask

   task automatic test_back_to_back();
      load_ac(16'h0000);
      dif.mac_valid = 1'b1;
      dif.mac_a_idx = 3'd0;
      dif.mac_b_idx = 3'd1;
      repeat (3) step();
      idle();
      repeat (MAC_STAGES) step();
      checks++;
      if (dif.ac_value !== 16'h0900) begin
         errors++;
         $display("FAIL mac_b2b: ac=%h required 0900", dif.ac_value);
      end
   endtask

   task automatic test_mac_overflow();
      logic [DATA_W-1:0] exp_ac;
`ifdef MAC_SAT_EN
      exp_ac = 16'h7FFF;
`else
      exp_ac = 16'h8100;
`endif
      load_reg(2, 16'h0200);
      load_reg(3, 16'h0100);
      load_ac(16'h7F00);
      dif.flag_clr = 1'b1;
      step();
      idle();
      issue(2, 3);
      repeat (MAC_STAGES) step();
      checks++;
      if (dif.ac_value !== exp_ac || dif.ovf !== 1'b1) begin
         errors++;
         $display("FAIL mac_ovf: ac=%h ovf=%b required %h 1", dif.ac_value, dif.ovf, exp_ac);
      end
      dif.flag_clr = 1'b1;
      step();
      idle();
      checks++;
      if (dif.ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: ovf=%b required 0", dif.ovf);
      end
      // Overflow retiring in the same cycle as flag_clr keeps ovf set.
      load_ac(16'h7F00);
      issue(2, 3);
      repeat (MAC_STAGES - 1) step();
      dif.flag_clr = 1'b1;
      step();
      idle();
      checks++;
      if (dif.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_vs_clr: ovf=%b required 1", dif.ovf);
      end
      // ac_load wins over the retiring result, ovf still records the retire.
      dif.flag_clr = 1'b1;
      step();
      idle();
      load_ac(16'h7F00);
      issue(2, 3);
      repeat (MAC_STAGES - 1) step();
      drive_mem(16'h1234);
      dif.ac_load = 1'b1;
      step();
      idle();
      checks++;
      if (dif.ac_value !== 16'h1234 || dif.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ac_load_vs_retire: ac=%h ovf=%b required 1234 1", dif.ac_value, dif.ovf);
      end
   endtask

   task automatic test_random_mac();
      logic [DATA_W-1:0] rm [NREG];
      logic [DATA_W-1:0] acc;
      bit ov, o;
      int e, v;
      mac_op_t op;
      mac_op_t pend[$];
      for (int k = 0; k < NREG; k++) begin
         if (k < 2) begin
            rm[k] = DATA_W'($urandom());
         end else begin
            v = int'($urandom_range(0, 4095)) - 2048;
            rm[k] = DATA_W'(v);
         end
         load_reg(k, rm[k]);
      end
      acc = DATA_W'($urandom());
      load_ac(acc);
      dif.flag_clr = 1'b1;
      step();
      idle();
      ov = 1'b0;
      e = 0;
      for (int n = 0; n < 60 + MAC_STAGES; n++) begin
         if (n < 60 && $urandom_range(0, 3) != 0) begin
            op.a = '0;
            op.b = '0;
            dif.mac_valid = 1'b1;
            dif.mac_a_idx = IDX_W'($urandom_range(0, NREG - 1));
            dif.mac_b_idx = IDX_W'($urandom_range(0, NREG - 1));
            // Occasionally overwrite an operand register in the issue cycle.
            if ($urandom_range(0, 7) == 0) begin
               drive_mem(DATA_W'($urandom()));
               dif.reg_load = NREG'(1) << dif.mac_a_idx;
            end
            op.ret = e + 1 + MAC_STAGES;
            op.a = rm[dif.mac_a_idx];
            op.b = rm[dif.mac_b_idx];
            pend.push_back(op);
            if (dif.reg_load != '0) rm[dif.mac_a_idx] = dif.from_memory;
         end
         step();
         idle();
         e++;
         while (pend.size() > 0 && pend[0].ret == e) begin
            op = pend.pop_front();
            acc = mac_ref(acc, op.a, op.b, o);
            ov = ov | o;
         end
         checks++;
         if (dif.ac_value !== acc) begin
            errors++;
            $display("FAIL rand_mac: cycle=%0d ac=%h required %h", n, dif.ac_value, acc);
         end
      end
      checks++;
      if (dif.ovf !== ov || dif.mac_busy !== 1'b0) begin
         errors++;
         $display("FAIL rand_mac_end: ovf=%b busy=%b required %b 0", dif.ovf, dif.mac_busy, ov);
      end
   endtask

   task automatic test_reset_mid_mac();
      load_reg(0, 16'h0200);
      load_reg(1, 16'h0180);
      load_ac(16'h0011);
      issue(0, 1);
      idle();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dif.ac_value !== '0 || dif.mac_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: ac=%h busy=%b required 0000 0", dif.ac_value, dif.mac_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < MAC_STAGES + 2; c++) begin
         step();
         checks++;
         if (dif.ac_value !== '0 || dif.mac_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_retire: cycle=%0d ac=%h busy=%b required 0000 0",
                     c, dif.ac_value, dif.mac_busy);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pc_ar();
      test_bus_flags();
      test_loops();
      test_mac_single();
      test_back_to_back();
      test_mac_overflow();
      test_random_mac();
      test_reset_mid_mac();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
